// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_ctrl
//  Purpose  : One-entry issue buffer between the decoder and the ROB /
//             reservation station / load-store buffer. Classifies the
//             buffered opcode, checks resource availability, issues or drops
//             the entry and keeps issue/stall performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dispatch_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  // decoder side
  input  logic             decEmpty_i,
  input  logic [5:0]       decOp_i,
  input  logic [4:0]       decR1_i,
  input  logic [4:0]       decR2_i,
  input  logic [4:0]       decRd_i,
  input  logic [31:0]      decImm_i,
  input  logic [31:0]      decPc_i,
  output logic             fetchPop_o,
  // resource status
  input  logic             robFull_i,
  input  logic             rsFull_i,
  input  logic             lsbFull_i,
  input  logic [TAG_W-1:0] robTag_i,
  input  logic             flush_i,
  // issue side
  output logic             robEn_o,
  output logic             rsEn_o,
  output logic             lsbEn_o,
  output logic             renameEn_o,
  output logic [5:0]       issOp_o,
  output logic [4:0]       issR1_o,
  output logic [4:0]       issR2_o,
  output logic [4:0]       issRd_o,
  output logic [31:0]      issImm_o,
  output logic [31:0]      issPc_o,
  output logic [TAG_W-1:0] issTag_o,
  // performance counters
  output logic [31:0]      issueCnt_o,
  output logic [31:0]      stallCnt_o
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  r1_q, r1_d;
  logic [4:0]  r2_q, r2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic op_is_rs;
  logic op_is_lsb;
  logic op_no_rd;
  logic res_ready;
  logic active;
  logic issue;
  logic drop;
  logic stall;
  logic pop;

  // Classify the buffered opcode and derive issue / drop / stall / pop
  always_comb begin
    op_is_lsb = (op_q >= 6'd11) && (op_q <= 6'd18);
    op_is_rs  = ((op_q >= 6'd1) && (op_q <= 6'd10)) ||
                ((op_q >= 6'd19) && (op_q <= 6'd37));
    // branches (5-10) and stores (16-18) have no destination register
    op_no_rd  = ((op_q >= 6'd5) && (op_q <= 6'd10)) ||
                ((op_q >= 6'd16) && (op_q <= 6'd18));
    res_ready = !robFull_i &&
                ((op_is_lsb && !lsbFull_i) || (op_is_rs && !rsFull_i));
    active    = (state_q == ST_FULL) && rdy && !flush_i;
    issue     = active && (op_is_rs || op_is_lsb) && res_ready;
    drop      = active && !(op_is_rs || op_is_lsb);
    stall     = active && (op_is_rs || op_is_lsb) && !res_ready;
    // rst is folded in so nothing is popped while reset is held
    pop       = rst && rdy && !flush_i && !decEmpty_i &&
                ((state_q == ST_EMPTY) || issue || drop);
  end

  // Next-state, buffer and counter update; everything holds when rdy is low
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rdy) begin
      if (flush_i || (!pop && (issue || drop))) begin
        // leaving FULL always clears the buffer so EMPTY presents zeros
        state_d = ST_EMPTY;
        op_d    = '0;
        r1_d    = '0;
        r2_d    = '0;
        rd_d    = '0;
        imm_d   = '0;
        pc_d    = '0;
      end else if (pop) begin
        state_d = ST_FULL;
        op_d    = decOp_i;
        r1_d    = decR1_i;
        r2_d    = decR2_i;
        rd_d    = decRd_i;
        imm_d   = decImm_i;
        pc_d    = decPc_i;
      end
      if (issue) issue_cnt_d = issue_cnt_q + 32'd1;
      if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State, buffer and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      op_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Issue-side outputs: enables from the live issue decision, fields from the buffer
  always_comb begin
    fetchPop_o = pop;
    robEn_o    = issue;
    rsEn_o     = issue && op_is_rs;
    lsbEn_o    = issue && op_is_lsb;
    renameEn_o = issue && (rd_q != 5'd0) && !op_no_rd;
    issOp_o    = op_q;
    issR1_o    = r1_q;
    issR2_o    = r2_q;
    issRd_o    = rd_q;
    issImm_o   = imm_q;
    issPc_o    = pc_q;
    issTag_o   = robTag_i;
    issueCnt_o = issue_cnt_q;
    stallCnt_o = stall_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_ctrl
//  Purpose  : Self-checking bench for dispatch_ctrl: directed scenarios plus
//             randomized traffic compared against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_ctrl;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             decEmpty_i;
  logic [5:0]       decOp_i;
  logic [4:0]       decR1_i, decR2_i, decRd_i;
  logic [31:0]      decImm_i, decPc_i;
  logic             fetchPop_o;
  logic             robFull_i, rsFull_i, lsbFull_i;
  logic [TAG_W-1:0] robTag_i;
  logic             flush_i;
  logic             robEn_o, rsEn_o, lsbEn_o, renameEn_o;
  logic [5:0]       issOp_o;
  logic [4:0]       issR1_o, issR2_o, issRd_o;
  logic [31:0]      issImm_o, issPc_o;
  logic [TAG_W-1:0] issTag_o;
  logic [31:0]      issueCnt_o, stallCnt_o;

  dispatch_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .decEmpty_i(decEmpty_i), .decOp_i(decOp_i), .decR1_i(decR1_i),
    .decR2_i(decR2_i), .decRd_i(decRd_i), .decImm_i(decImm_i),
    .decPc_i(decPc_i), .fetchPop_o(fetchPop_o),
    .robFull_i(robFull_i), .rsFull_i(rsFull_i), .lsbFull_i(lsbFull_i),
    .robTag_i(robTag_i), .flush_i(flush_i),
    .robEn_o(robEn_o), .rsEn_o(rsEn_o), .lsbEn_o(lsbEn_o),
    .renameEn_o(renameEn_o), .issOp_o(issOp_o), .issR1_o(issR1_o),
    .issR2_o(issR2_o), .issRd_o(issRd_o), .issImm_o(issImm_o),
    .issPc_o(issPc_o), .issTag_o(issTag_o),
    .issueCnt_o(issueCnt_o), .stallCnt_o(stallCnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  r1, r2, rd;
    logic [31:0] imm, pc;
  } instr_t;

  // reference model: the buffer is a queue of at most one instruction
  instr_t      m_buf[$];
  logic [31:0] m_icnt, m_scnt;
  bit          e_issue, e_drop, e_stall, e_pop;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cls_rs(input int op);
    return (op >= 1 && op <= 10) || (op >= 19 && op <= 37);
  endfunction
  function automatic bit cls_lsb(input int op);
    return op >= 11 && op <= 18;
  endfunction
  function automatic bit has_rd(input int op);
    return !((op >= 5 && op <= 10) || (op >= 16 && op <= 18));
  endfunction

  // compare all outputs against the model for the current inputs
  task automatic check_outputs();
    instr_t b;
    bit full, legal, res_ok, act;
    full   = (m_buf.size() != 0);
    b      = full ? m_buf[0] : '0;
    legal  = cls_rs(int'(b.op)) || cls_lsb(int'(b.op));
    res_ok = !robFull_i && (cls_lsb(int'(b.op)) ? !lsbFull_i : !rsFull_i);
    act    = full && rdy && !flush_i;
    e_issue = act && legal && res_ok;
    e_drop  = act && !legal;
    e_stall = act && legal && !res_ok;
    e_pop   = rdy && !flush_i && !decEmpty_i && (!full || e_issue || e_drop);
    chk("fetchPop", 32'(fetchPop_o), 32'(e_pop));
    chk("robEn",    32'(robEn_o),    32'(e_issue));
    chk("rsEn",     32'(rsEn_o),     32'(e_issue && cls_rs(int'(b.op))));
    chk("lsbEn",    32'(lsbEn_o),    32'(e_issue && cls_lsb(int'(b.op))));
    chk("renameEn", 32'(renameEn_o), 32'(e_issue && b.rd != 0 && has_rd(int'(b.op))));
    chk("issOp",    32'(issOp_o),    32'(b.op));
    chk("issR1",    32'(issR1_o),    32'(b.r1));
    chk("issR2",    32'(issR2_o),    32'(b.r2));
    chk("issRd",    32'(issRd_o),    32'(b.rd));
    chk("issImm",   issImm_o,        b.imm);
    chk("issPc",    issPc_o,         b.pc);
    chk("issTag",   32'(issTag_o),   32'(robTag_i));
    chk("issueCnt", issueCnt_o,      m_icnt);
    chk("stallCnt", stallCnt_o,      m_scnt);
  endtask

  // one clock: check mid-cycle, then advance the model at the edge
  task automatic step();
    instr_t d;
    @(negedge clk);
    check_outputs();
    d = '{op: decOp_i, r1: decR1_i, r2: decR2_i, rd: decRd_i, imm: decImm_i, pc: decPc_i};
    @(posedge clk);
    if (rdy) begin
      if (flush_i) m_buf.delete();
      else if (e_pop) begin
        m_buf.delete();
        m_buf.push_back(d);
      end else if (e_issue || e_drop) m_buf.delete();
      if (e_issue) m_icnt = m_icnt + 32'd1;
      if (e_stall) m_scnt = m_scnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; decEmpty_i = 1'b1; flush_i = 1'b0;
    robFull_i = 1'b0; rsFull_i = 1'b0; lsbFull_i = 1'b0;
  endtask

  task automatic dec(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc);
    decEmpty_i = 1'b0; decOp_i = op; decRd_i = rd; decPc_i = pc;
    decR1_i = 5'(pc[4:0] + 5'd1); decR2_i = 5'(pc[4:0] + 5'd2);
    decImm_i = pc ^ 32'hA5A5_0000;
  endtask

  initial begin
    logic [31:0] c_i, c_s;
    rst = 1'b0; idle();
    decOp_i = '0; decR1_i = '0; decR2_i = '0; decRd_i = '0;
    decImm_i = '0; decPc_i = '0; robTag_i = '0;
    m_icnt = '0; m_scnt = '0;
    #2;
    // reset state: nothing popped even with a valid decoded instruction
    dec(6'd28, 5'd3, 32'h100);
    #1;
    chk("rst_fetchPop", 32'(fetchPop_o), 32'd0);
    chk("rst_issPc", issPc_o, 32'd0);
    chk("rst_issueCnt", issueCnt_o, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    idle();

    // back-to-back ADD, LW, SW
    c_i = issueCnt_o;
    dec(6'd28, 5'd3, 32'h100); step();
    dec(6'd13, 5'd4, 32'h104); step();
    dec(6'd18, 5'd5, 32'h108); step();
    decEmpty_i = 1'b1; step();
    step();
    chk("b2b_issued", issueCnt_o - c_i, 32'd3);

    // LSB stall for 4 cycles, next instruction waiting behind it
    c_s = stallCnt_o;
    lsbFull_i = 1'b1;
    dec(6'd13, 5'd6, 32'h200); step();
    dec(6'd28, 5'd7, 32'h204);
    repeat (4) step();
    chk("stall_pc", issPc_o, 32'h200);
    chk("stall_cnt", stallCnt_o - c_s, 32'd4);
    lsbFull_i = 1'b0; step();
    decEmpty_i = 1'b1; step(); step();

    // flush during RS stall on a branch
    rsFull_i = 1'b1;
    dec(6'd5, 5'd0, 32'h300); step();
    decEmpty_i = 1'b1; step();
    flush_i = 1'b1; dec(6'd28, 5'd1, 32'h304); step();
    flush_i = 1'b0; decEmpty_i = 1'b1; rsFull_i = 1'b0;
    chk("flush_pc", issPc_o, 32'd0);
    step();

    // NOP, illegal, ADDI
    c_i = issueCnt_o;
    dec(6'd0,  5'd1, 32'h400); step();
    dec(6'd45, 5'd2, 32'h404); step();
    dec(6'd19, 5'd3, 32'h408); step();
    decEmpty_i = 1'b1; step(); step();
    chk("nop_ill_issued", issueCnt_o - c_i, 32'd1);

    // rdy gating
    dec(6'd28, 5'd9, 32'h500); step();
    c_i = issueCnt_o; c_s = stallCnt_o;
    rdy = 1'b0; decEmpty_i = 1'b1;
    repeat (3) step();
    chk("rdy_icnt", issueCnt_o, c_i);
    chk("rdy_scnt", stallCnt_o, c_s);
    chk("rdy_pc", issPc_o, 32'h500);
    rdy = 1'b1; step(); step();

    // async reset mid-stall, then JAL with rd=x0
    rsFull_i = 1'b1;
    dec(6'd28, 5'd10, 32'h600); step();
    decEmpty_i = 1'b1; step();
    #2 rst = 1'b0;
    #1;
    chk("arst_rsEn", 32'(rsEn_o), 32'd0);
    chk("arst_fetchPop", 32'(fetchPop_o), 32'd0);
    chk("arst_issPc", issPc_o, 32'd0);
    chk("arst_issueCnt", issueCnt_o, 32'd0);
    chk("arst_stallCnt", stallCnt_o, 32'd0);
    m_buf.delete(); m_icnt = '0; m_scnt = '0;
    @(posedge clk); #1 rst = 1'b1;
    idle();
    dec(6'd3, 5'd0, 32'h700); step();
    decEmpty_i = 1'b1; step(); step();
    chk("jal_issued", issueCnt_o, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rdy        = ($urandom_range(7) != 0);
      flush_i    = ($urandom_range(15) == 0);
      robFull_i  = ($urandom_range(5) == 0);
      rsFull_i   = ($urandom_range(3) == 0);
      lsbFull_i  = ($urandom_range(3) == 0);
      robTag_i   = TAG_W'($urandom);
      decEmpty_i = ($urandom_range(3) == 0);
      decOp_i    = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(37));
      decR1_i    = 5'($urandom);
      decR2_i    = 5'($urandom);
      decRd_i    = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
      decImm_i   = $urandom;
      decPc_i    = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, meaning ROB tag width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port rdy, input, 1 bit: global enable; when low, all state is frozen.
REQ-005 The block SHALL have the following decoder-side inputs:
- decEmpty_i, 1 bit: no valid decoded instruction.
- decOp_i, 6 bits: decoded opcode.
- decR1_i, decR2_i, decRd_i, 5 bits each: register addresses.
- decImm_i, decPc_i, 32 bits each: immediate and PC.
REQ-006 The block SHALL have output fetchPop_o, 1 bit: pop instruction queue head.
REQ-007 The block SHALL have the following resource-status inputs:
- robFull_i, rsFull_i, lsbFull_i, 1 bit each.
- robTag_i, TAG_W bits: next free ROB tag.
- flush_i, 1 bit: mispredict flush.
REQ-008 The block SHALL have the following issue outputs:
- robEn_o, rsEn_o, lsbEn_o, renameEn_o, 1 bit each.
- issOp_o, 6 bits.
- issR1_o, issR2_o, issRd_o, 5 bits each.
- issImm_o, issPc_o, 32 bits each.
- issTag_o, TAG_W bits.
REQ-009 The block SHALL have outputs issueCnt_o and stallCnt_o, 32 bits each: performance counters.

Function
REQ-010 Opcode classes SHALL be fixed as follows:
- 0: NOP.
- 1-10: LUI, AUIPC, JAL, JALR, BEQ..BGEU (ALU-RS).
- 11-15: loads (LSB).
- 16-18: stores (LSB).
- 19-37: OP-IMM and OP (ALU-RS).
- 38-63: illegal.
REQ-011 The block SHALL hold a one-entry issue buffer with FSM states EMPTY and FULL; the buffer captures all dec*_i fields.
REQ-012 ready SHALL be defined as: robFull_i=0, and lsbFull_i=0 for opcodes 11-18 or rsFull_i=0 for opcodes 1-10 and 19-37.
REQ-013 issue SHALL be combinational: state FULL, rdy=1, flush_i=0, opcode in 1-37, and ready.
REQ-014 drop SHALL be combinational: state FULL, rdy=1, flush_i=0, and opcode 0 or 38-63; a dropped entry generates no enables.
REQ-015 fetchPop_o SHALL equal rdy and not flush_i and not decEmpty_i, and (state EMPTY, or issue, or drop).
REQ-016 Enable outputs SHALL be driven as follows:
- On issue, robEn_o=1.
- On issue, rsEn_o=1 for RS-class opcodes; lsbEn_o=1 for LSB-class opcodes; never both.
- renameEn_o=1 iff issue and buffered rd≠0 and opcode not in 5-10 or 16-18.
REQ-017 issOp_o, issR1_o, issR2_o, issRd_o, issImm_o and issPc_o SHALL reflect the buffer contents whenever state is FULL, and SHALL be 0 when EMPTY.
REQ-018 issTag_o SHALL equal robTag_i combinationally.
REQ-019 Transitions at a clock edge with rdy=1 SHALL be:
- flush_i=1 → EMPTY, buffer zeroed, regardless of other inputs.
- Otherwise, fetchPop_o=1 → FULL, buffer loads dec*_i.
- Otherwise, issue or drop → EMPTY.
- Otherwise, the state is held.
REQ-020 Simultaneous issue and pop SHALL sustain a throughput of one instruction per cycle with no bubble.
REQ-021 Latency SHALL be: an instruction popped at edge N is issuable in the cycle following edge N, i.e. a 1-cycle minimum.
REQ-022 issueCnt_o SHALL increment by 1 at each edge where issue=1.
REQ-023 stallCnt_o SHALL increment at each edge where state is FULL, rdy=1, flush_i=0, opcode is in 1-37, and ready=0.
REQ-024 Both counters SHALL wrap modulo 2^32.
REQ-025 With rdy=0, all enables and fetchPop_o SHALL be 0, and state, buffer and counters SHALL be held.
REQ-026 Buffered fields SHALL never change while FULL unless the entry is issued, dropped or flushed.

Reset
REQ-027 While rst=0, asynchronously: state EMPTY, buffer 0, counters 0, all enables and fetchPop_o 0.
REQ-028 Reset asserted mid-stall SHALL discard the buffered instruction with no issue and no pop.
REQ-029 After rst rises, the first pop SHALL occur no earlier than the first edge at which rdy=1 and decEmpty_i=0.

Verification
REQ-030 The bench SHALL cover back-to-back flow: ADD (op 28), then LW (op 13), then SW (op 18), with all resources free. Required response:
- fetchPop_o high 3 consecutive cycles.
- rsEn_o, then lsbEn_o, then lsbEn_o, one per cycle.
- renameEn_o 1,1,0.
- issueCnt_o=3.
REQ-031 The bench SHALL cover an LSB stall: LW buffered with lsbFull_i=1 for 4 cycles, then 0. Required response:
- lsbEn_o=0 and fetchPop_o=0 for those 4 cycles; stallCnt_o=4.
- Issue in the 5th cycle with the same issPc_o.
REQ-032 The bench SHALL cover a flush during a stall: BEQ (op 5) stalled on rsFull_i, then flush_i=1 for 1 cycle. Required response:
- No rsEn_o and no fetchPop_o in the flush cycle.
- State EMPTY next cycle; issPc_o=0.
REQ-033 The bench SHALL cover NOP and illegal opcodes: op 0, then op 45, then ADDI (op 19). Required response:
- No enables for the first two.
- fetchPop_o every cycle.
- rsEn_o only for ADDI; issueCnt_o=1.
REQ-034 The bench SHALL cover rdy gating: ADD buffered and rdy=0 for 3 cycles. Required response:
- No enables, counters unchanged.
- With rdy=1, rsEn_o next cycle.
REQ-035 The bench SHALL cover asynchronous reset and the x0 destination: rst pulsed low between edges while FULL. Required response:
- Outputs zero immediately.
- A subsequent JAL with rd=0 issues with renameEn_o=0.
